// File: rtl/rom_stream_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : rom_stream_sequencer
//  Description : Reads a three-word header (opcode, argument, stop byte) from
//                a combinational ROM, then walks the payload area decoding one
//                byte per word and streams it out over a valid/ready
//                handshake until the decoded stop byte or the end of the ROM.
//  Revision    : 1.0 - initial release
// ============================================================================
module rom_stream_sequencer #(
    parameter logic [10:0] DATA_BASE = 11'h00C,
    parameter logic [10:0] ADDR_LAST = 11'h7FC
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic [10:0] rom_addr,
    input  logic [31:0] rom_data,
    output logic [7:0]  out_byte,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err,
    output logic [8:0]  byte_count
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_HDR_OP   = 3'd1,
        S_HDR_ARG  = 3'd2,
        S_HDR_STOP = 3'd3,
        S_FETCH    = 3'd4,
        S_EMIT     = 3'd5,
        S_DONE     = 3'd6,
        S_ERR      = 3'd7
    } state_t;

    localparam logic [10:0] c_ADDR_OP   = 11'h000;
    localparam logic [10:0] c_ADDR_ARG  = 11'h004;
    localparam logic [10:0] c_ADDR_STOP = 11'h008;
    localparam logic [10:0] c_ADDR_STEP = 11'h004;
    localparam logic [1:0]  c_ERR_NONE  = 2'b00;
    localparam logic [1:0]  c_ERR_OP    = 2'b01;
    localparam logic [1:0]  c_ERR_OVR   = 2'b10;

    state_t      r_state,      w_state_nxt;
    logic [10:0] r_rom_addr,   w_rom_addr_nxt;
    logic [7:0]  r_out_byte,   w_out_byte_nxt;
    logic        r_out_valid,  w_out_valid_nxt;
    logic [1:0]  r_err,        w_err_nxt;
    logic [8:0]  r_byte_count, w_byte_count_nxt;
    logic [1:0]  r_op,         w_op_nxt;
    logic [7:0]  r_arg,        w_arg_nxt;
    logic [7:0]  r_stop,       w_stop_nxt;
    logic [7:0]  w_decoded;

    // Payload decode of the word currently presented by the ROM
    always_comb begin
        w_decoded = rom_data[7:0];
        case (r_op)
            2'd1:    w_decoded = rom_data[7:0] ^ r_arg;
            2'd2:    w_decoded = ~rom_data[7:0];
            2'd3:    w_decoded = rom_data[7:0] + r_arg;
            default: w_decoded = rom_data[7:0];
        endcase
    end

    // Next-state and next-register-value logic for the sequencer
    always_comb begin
        w_state_nxt      = r_state;
        w_rom_addr_nxt   = r_rom_addr;
        w_out_byte_nxt   = r_out_byte;
        w_out_valid_nxt  = r_out_valid;
        w_err_nxt        = r_err;
        w_byte_count_nxt = r_byte_count;
        w_op_nxt         = r_op;
        w_arg_nxt        = r_arg;
        w_stop_nxt       = r_stop;

        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    w_state_nxt      = S_HDR_OP;
                    w_rom_addr_nxt   = c_ADDR_OP;
                    w_byte_count_nxt = 9'd0;
                    w_err_nxt        = c_ERR_NONE;
                end
            end
            S_HDR_OP: begin
                // Only opcodes 1..3 with all upper bits clear are legal
                if ((rom_data[31:2] != 30'd0) || (rom_data[1:0] == 2'd0)) begin
                    w_state_nxt = S_ERR;
                    w_err_nxt   = c_ERR_OP;
                end else begin
                    w_op_nxt       = rom_data[1:0];
                    w_rom_addr_nxt = c_ADDR_ARG;
                    w_state_nxt    = S_HDR_ARG;
                end
            end
            S_HDR_ARG: begin
                w_arg_nxt      = rom_data[7:0];
                w_rom_addr_nxt = c_ADDR_STOP;
                w_state_nxt    = S_HDR_STOP;
            end
            S_HDR_STOP: begin
                w_stop_nxt     = rom_data[7:0];
                w_rom_addr_nxt = DATA_BASE;
                w_state_nxt    = S_FETCH;
            end
            S_FETCH: begin
                // The terminator ends the run and is never presented downstream
                if (w_decoded == r_stop) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_out_byte_nxt  = w_decoded;
                    w_out_valid_nxt = 1'b1;
                    w_state_nxt     = S_EMIT;
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    w_byte_count_nxt = r_byte_count + 9'd1;
                    w_out_valid_nxt  = 1'b0;
                    if (r_rom_addr == ADDR_LAST) begin
                        w_state_nxt = S_ERR;
                        w_err_nxt   = c_ERR_OVR;
                    end else begin
                        w_rom_addr_nxt = r_rom_addr + c_ADDR_STEP;
                        w_state_nxt    = S_FETCH;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_rom_addr   <= 11'd0;
            r_out_byte   <= 8'd0;
            r_out_valid  <= 1'b0;
            r_err        <= c_ERR_NONE;
            r_byte_count <= 9'd0;
            r_op         <= 2'd0;
            r_arg        <= 8'd0;
            r_stop       <= 8'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_rom_addr   <= w_rom_addr_nxt;
            r_out_byte   <= w_out_byte_nxt;
            r_out_valid  <= w_out_valid_nxt;
            r_err        <= w_err_nxt;
            r_byte_count <= w_byte_count_nxt;
            r_op         <= w_op_nxt;
            r_arg        <= w_arg_nxt;
            r_stop       <= w_stop_nxt;
        end
    end

    assign rom_addr   = r_rom_addr;
    assign out_byte   = r_out_byte;
    assign out_valid  = r_out_valid;
    assign err        = r_err;
    assign byte_count = r_byte_count;
    assign busy       = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_ERR);
    assign done       = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_rom_stream_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rom_stream_sequencer
//  Description : Self-checking bench for rom_stream_sequencer. A default
//                instance and a short-ROM instance share one ROM image; each
//                run is compared against a decode model of the ROM contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_stream_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        out_ready;
    logic        sel;               // 0: default instance, 1: short-ROM instance

    logic [31:0] rom [0:511];

    logic [10:0] addr_a, addr_b;
    logic [7:0]  ob_a, ob_b;
    logic        ov_a, ov_b, busy_a, busy_b, done_a, done_b;
    logic [1:0]  err_a, err_b;
    logic [8:0]  bc_a, bc_b;
    logic        start_a, start_b;
    logic [31:0] rd_a, rd_b;

    logic [10:0] m_addr;
    logic [7:0]  m_ob;
    logic        m_ov, m_busy, m_done;
    logic [1:0]  m_err;
    logic [8:0]  m_bc;

    assign start_a = start & ~sel;
    assign start_b = start & sel;
    assign rd_a    = rom[addr_a[10:2]];
    assign rd_b    = rom[addr_b[10:2]];
    assign m_addr  = sel ? addr_b : addr_a;
    assign m_ob    = sel ? ob_b   : ob_a;
    assign m_ov    = sel ? ov_b   : ov_a;
    assign m_busy  = sel ? busy_b : busy_a;
    assign m_done  = sel ? done_b : done_a;
    assign m_err   = sel ? err_b  : err_a;
    assign m_bc    = sel ? bc_b   : bc_a;

    rom_stream_sequencer u_dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .rom_addr(addr_a),
        .rom_data(rd_a), .out_byte(ob_a), .out_valid(ov_a), .out_ready(out_ready),
        .busy(busy_a), .done(done_a), .err(err_a), .byte_count(bc_a)
    );

    rom_stream_sequencer #(.DATA_BASE(11'h00C), .ADDR_LAST(11'h014)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .rom_addr(addr_b),
        .rom_data(rd_b), .out_byte(ob_b), .out_valid(ov_b), .out_ready(out_ready),
        .busy(busy_b), .done(done_b), .err(err_b), .byte_count(bc_b)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model: decode the ROM image directly --------
    logic [7:0]  exp_q[$];
    logic [1:0]  exp_err;
    logic        exp_done;
    logic [10:0] exp_addr;

    task automatic model(input int last_addr);
        logic [31:0] hdr;
        logic [1:0]  op;
        logic [7:0]  arg, stp, d, dec;
        int          a;
        exp_q.delete();
        exp_err  = 2'd0;
        exp_done = 1'b0;
        exp_addr = 11'd0;
        hdr = rom[0];
        if ((hdr >> 2) != 0 || hdr[1:0] == 2'd0) begin
            exp_err = 2'd1;
            return;
        end
        op  = hdr[1:0];
        arg = rom[1][7:0];
        stp = rom[2][7:0];
        a   = 12;
        while (1) begin
            d = rom[a / 4][7:0];
            if (op == 2'd1)      dec = d ^ arg;
            else if (op == 2'd2) dec = ~d;
            else                 dec = 8'((int'(d) + int'(arg)) % 256);
            if (dec == stp) begin
                exp_done = 1'b1;
                exp_addr = 11'(a);
                break;
            end
            exp_q.push_back(dec);
            if (a == last_addr) begin
                exp_err  = 2'd2;
                exp_addr = 11'(a);
                break;
            end
            a += 4;
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 512; i++) rom[i] = 32'd0;
    endtask

    // ---------------- one run: start, stream with random backpressure -------
    task automatic run(input string tag, input int start_len, input int ready_pct);
        logic [7:0] obs_q[$];
        int   cyc, first_valid, last_xfer;
        logic prev_valid, prev_ready, timed_out;
        logic [7:0] prev_byte;
        cyc = 0; first_valid = -1; last_xfer = -1;
        prev_valid = 1'b0; prev_ready = 1'b0; prev_byte = 8'd0; timed_out = 1'b0;
        start = 1'b1;
        out_ready = 1'b0;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (cyc >= start_len) start = 1'b0;
            if (prev_valid && !prev_ready) begin
                chk($sformatf("%s.hold_valid@%0d", tag, cyc), 32'(m_ov), 32'd1);
                chk($sformatf("%s.hold_byte@%0d", tag, cyc), 32'(m_ob), 32'(prev_byte));
            end
            if (m_ov && !prev_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (last_xfer >= 0)
                    chk($sformatf("%s.gap@%0d", tag, cyc), 32'(cyc - last_xfer), 32'd2);
            end
            if (!m_busy && !m_ov) break;
            if (cyc > 3000) begin
                timed_out = 1'b1;
                break;
            end
            out_ready = ($urandom_range(99) < ready_pct);
            if (m_ov && out_ready) begin
                obs_q.push_back(m_ob);
                last_xfer = cyc;
            end
            prev_valid = m_ov;
            prev_ready = out_ready;
            prev_byte  = m_ob;
        end
        start = 1'b0;
        chk({tag, ".timeout"}, 32'(timed_out), 32'd0);
        chk({tag, ".nbytes"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s.byte%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
        chk({tag, ".byte_count"}, 32'(m_bc), 32'(exp_q.size()));
        chk({tag, ".done"}, 32'(m_done), 32'(exp_done));
        chk({tag, ".err"}, 32'(m_err), 32'(exp_err));
        chk({tag, ".rom_addr"}, 32'(m_addr), 32'(exp_addr));
        if (exp_q.size() > 0) chk({tag, ".latency"}, 32'(first_valid), 32'd5);
        else                  chk({tag, ".no_valid"}, 32'(first_valid), 32'hFFFF_FFFF);
        repeat (2) @(negedge clk);
        chk({tag, ".hold_done"}, 32'(m_done), 32'(exp_done));
        chk({tag, ".hold_err"}, 32'(m_err), 32'(exp_err));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".rom_addr"}, 32'(m_addr), 32'd0);
        chk({tag, ".out_byte"}, 32'(m_ob), 32'd0);
        chk({tag, ".out_valid"}, 32'(m_ov), 32'd0);
        chk({tag, ".done"}, 32'(m_done), 32'd0);
        chk({tag, ".busy"}, 32'(m_busy), 32'd0);
        chk({tag, ".err"}, 32'(m_err), 32'd0);
        chk({tag, ".byte_count"}, 32'(m_bc), 32'd0);
    endtask

    initial begin
        string       msg;
        logic [1:0]  rop;
        logic [7:0]  rarg, rstp, enc;
        int          len, guard;

        reset_n = 1'b0; start = 1'b0; out_ready = 1'b0; sel = 1'b0;
        clear_rom();
        repeat (3) @(negedge clk);
        chk_reset_vals("reset_a");
        reset_n = 1'b1;
        @(negedge clk);

        // Welcome message, op 2 (invert), consumer always ready
        clear_rom();
        rom[0] = 32'd2; rom[1] = 32'd7; rom[2] = 32'h26;
        rom[3] = 32'h5E;
        msg = "Welcome to the Jungle!";
        for (int i = 0; i < msg.len(); i++) rom[4 + i] = {24'd0, ~msg[i]};
        rom[4 + msg.len()] = 32'hD9;
        model(11'h7FC);
        chk("welcome.model_len", 32'(exp_q.size()), 32'd23);
        run("welcome", 1, 100);

        // XOR decode, start held across several busy cycles
        clear_rom();
        rom[0] = 32'd1; rom[1] = 32'h07; rom[2] = 32'h26; rom[3] = 32'h46; rom[4] = 32'h21;
        model(11'h7FC);
        run("op1", 3, 100);

        // Additive decode with 8-bit wrap
        clear_rom();
        rom[0] = 32'd3; rom[1] = 32'h10; rom[2] = 32'h26; rom[3] = 32'hF8; rom[4] = 32'h16;
        model(11'h7FC);
        run("op3", 1, 50);

        // Illegal opcode word
        clear_rom();
        rom[0] = 32'h0000_0004;
        model(11'h7FC);
        run("badop", 1, 100);

        // Randomised header and payload under random backpressure
        for (int r = 0; r < 6; r++) begin
            clear_rom();
            rop  = 2'($urandom_range(1, 3));
            rarg = 8'($urandom);
            rstp = 8'($urandom);
            len  = $urandom_range(0, 30);
            rom[0] = {30'd0, rop}; rom[1] = $urandom; rom[2] = $urandom;
            rom[1][7:0] = rarg; rom[2][7:0] = rstp;
            for (int i = 0; i < len; i++) rom[3 + i] = $urandom;
            if (rop == 2'd1)      enc = rstp ^ rarg;
            else if (rop == 2'd2) enc = ~rstp;
            else                  enc = rstp - rarg;
            rom[3 + len] = {$urandom_range(0, 255), 16'hA5A5, enc};
            model(11'h7FC);
            run($sformatf("rnd%0d", r), 1, 40);
        end

        // Short-ROM instance: stop byte never seen, address overrun
        sel = 1'b1;
        clear_rom();
        rom[0] = 32'd2; rom[1] = 32'd0; rom[2] = 32'h26;
        rom[3] = 32'h11; rom[4] = 32'h22; rom[5] = 32'h33;
        model(11'h014);
        run("overrun", 1, 60);

        // Reset while a byte is pending in EMIT
        start = 1'b1;
        out_ready = 1'b1;
        guard = 0;
        @(negedge clk);
        start = 1'b0;
        while (!(m_ov && m_bc == 9'd1) && guard < 50) begin
            if (m_ov) out_ready = 1'b1;
            @(negedge clk);
            if (m_bc == 9'd1) out_ready = 1'b0;
            guard++;
        end
        chk("rst_emit.reached", 32'(guard < 50), 32'd1);
        chk("rst_emit.pending_byte", 32'(m_ob), 32'hDD);
        reset_n = 1'b0;
        @(negedge clk);
        chk_reset_vals("rst_emit");
        reset_n = 1'b1;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
